// File: rtl/queue_pkg.sv
// Shared definitions for the queue wait-time estimator.
// Holds the default widths/service time and the calculator FSM state type.
package queue_pkg;

    localparam int unsigned PCNT_W_DEF    = 4;
    localparam int unsigned TCNT_W_DEF    = 2;
    localparam int unsigned SERVICE_T_DEF = 3;
    localparam int unsigned WT_W_DEF      = 6;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCalc,
        StDone
    } calc_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               load dividend/divisor; the first bit is produced on this same edge
//   dividend, divisor   W-bit operands (divisor must be nonzero)
//   quotient, remainder results, held until the next start
//   done                high once all W bits are resolved, stays high until the next start
module seq_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [W-1:0]  rem_in, quo_in, step_rem, step_quo;
    logic [W:0]    rem_sh, diff;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        // On start the step works on freshly loaded operands, saving a load cycle.
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        rem_sh   = {rem_in, quo_in[W-1]};
        diff     = rem_sh - {1'b0, divisor};
        step_rem = rem_sh[W-1:0];
        step_quo = {quo_in[W-2:0], 1'b0};
        if (rem_sh >= {1'b0, divisor}) begin
            step_rem    = diff[W-1:0];
            step_quo[0] = 1'b1;
        end

        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = CW'(W - 1);
            run_d = 1'b1;
        end else if (run_q && (cnt_q != '0)) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = run_q && (cnt_q == '0);

endmodule

// File: rtl/queue_wait_calc.sv
// Queue people counter with estimated wait time ceil(SERVICE_T*(p+t-1)/t).
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   enter, leave one-cycle pulses adding/removing one customer
//   tcount       number of active tellers, sampled every cycle
//   pcount       registered people count; ef/ff empty/full flags
//   wtime        registered wait estimate, saturating at all-ones
//   wvalid       wtime reflects the current pcount/tcount
//   busy         a calculation is in progress
module queue_wait_calc
    import queue_pkg::*;
#(
    parameter int unsigned PCNT_W    = PCNT_W_DEF,
    parameter int unsigned TCNT_W    = TCNT_W_DEF,
    parameter int unsigned SERVICE_T = SERVICE_T_DEF,
    parameter int unsigned WT_W      = WT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic              leave,
    input  logic [TCNT_W-1:0] tcount,
    output logic [PCNT_W-1:0] pcount,
    output logic              ef,
    output logic              ff,
    output logic [WT_W-1:0]   wtime,
    output logic              wvalid,
    output logic              busy
);
    localparam int unsigned NUM_W = PCNT_W + TCNT_W + $clog2(SERVICE_T + 1);
    localparam logic [PCNT_W-1:0] PMAX   = '1;
    localparam logic [WT_W-1:0]   WT_MAX = '1;

    calc_state_e       state_q, state_d;
    logic [PCNT_W-1:0] pcount_q, pcount_d, p_op_q;
    logic [TCNT_W-1:0] tcount_q, t_op_q;
    logic [WT_W-1:0]   wtime_q, result;
    logic              inc, dec, trig, special, div_start, div_done, wt_we;
    logic [NUM_W-1:0]  numer, denom, div_quo, div_rem;
    logic [NUM_W:0]    ceil_val;

    assign ef = (pcount_q == '0);
    assign ff = (pcount_q == PMAX);

    always_comb begin
        // Simultaneous enter/leave cancels out; out-of-range requests are dropped.
        inc      = enter && !leave && !ff;
        dec      = leave && !enter && !ef;
        pcount_d = pcount_q;
        if (inc) pcount_d = pcount_q + PCNT_W'(1);
        if (dec) pcount_d = pcount_q - PCNT_W'(1);
        trig = inc || dec || (tcount != tcount_q);
    end

    assign special = (p_op_q == '0) || (p_op_q == PMAX) || (t_op_q == '0);
    // Only evaluated for nonzero p and t, so the subtraction cannot wrap.
    assign numer = NUM_W'(SERVICE_T) * (NUM_W'(p_op_q) + NUM_W'(t_op_q) - NUM_W'(1));
    assign denom = NUM_W'(t_op_q);

    seq_divider #(
        .W(NUM_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (numer),
        .divisor  (denom),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    always_comb begin
        ceil_val = {1'b0, div_quo} + {{NUM_W{1'b0}}, (div_rem != '0)};
        if (p_op_q == '0) begin
            result = '0;
        end else if (special || (32'(ceil_val) > 32'(WT_MAX))) begin
            result = WT_MAX;
        end else begin
            result = WT_W'(ceil_val);
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        wt_we     = 1'b0;
        // Any trigger restarts from LOAD, which drops an in-flight result.
        unique case (state_q)
            StIdle: if (trig) state_d = StLoad;
            StLoad: begin
                if (trig) begin
                    state_d = StLoad;
                end else if (special) begin
                    state_d = StDone;
                end else begin
                    state_d   = StCalc;
                    div_start = 1'b1;
                end
            end
            StCalc: begin
                if (trig) state_d = StLoad;
                else if (div_done) state_d = StDone;
            end
            StDone: begin
                if (trig) begin
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                    wt_we   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pcount_q <= '0;
            tcount_q <= '0;
            p_op_q   <= '0;
            t_op_q   <= '0;
            wtime_q  <= '0;
        end else begin
            state_q  <= state_d;
            pcount_q <= pcount_d;
            tcount_q <= tcount;
            // Operands captured with the values becoming current on this edge.
            if (trig) begin
                p_op_q <= pcount_d;
                t_op_q <= tcount;
            end
            if (wt_we) wtime_q <= result;
        end
    end

    assign pcount = pcount_q;
    assign wtime  = wtime_q;
    assign wvalid = (state_q == StIdle);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_queue_wait_calc.sv
module tb_queue_wait_calc;
    localparam int PMAX      = 15;
    localparam int WT_MAX    = 63;
    localparam int SERVICE_T = 3;

    typedef struct {
        bit e;
        bit l;
        int tv;   // new tcount, or -1 to keep it
        int gap;  // idle cycles after this event
    } ev_t;

    typedef struct {
        int     wt;
        int     p;
        longint wcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0;
    logic       leave = 1'b0;
    logic [1:0] tcount = 2'd0;
    logic [3:0] pcount;
    logic       ef, ff, wvalid, busy;
    logic [5:0] wtime;

    int     n_pass = 0;
    int     n_total = 0;
    longint cyc = 0;
    int     mp = 0;
    int     mt = 0;
    ev_t    plan[$];
    exp_t   sb[$];

    queue_wait_calc #(
        .PCNT_W   (4),
        .TCNT_W   (2),
        .SERVICE_T(3),
        .WT_W     (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enter (enter),
        .leave (leave),
        .tcount(tcount),
        .pcount(pcount),
        .ef    (ef),
        .ff    (ff),
        .wtime (wtime),
        .wvalid(wvalid),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int ref_wait(input int p, input int t);
        int v;
        if (p == 0) return 0;
        if (p == PMAX || t == 0) return WT_MAX;
        v = (SERVICE_T * (p + t - 1) + t - 1) / t;
        return (v > WT_MAX) ? WT_MAX : v;
    endfunction

    task automatic add(input bit e, input bit l, input int tv, input int gap);
        ev_t ev;
        ev.e = e; ev.l = l; ev.tv = tv; ev.gap = gap;
        plan.push_back(ev);
    endtask

    task automatic settle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("settle_pending", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    // Predicts which results get written: a trigger at cycle c kills a pending
    // result due at or after c. Expectations are queued before driving.
    task automatic run_burst(input bit do_settle);
        int     p, t, nt;
        bit     inc, dec, pv;
        longint c;
        exp_t   pend;
        p = mp; t = mt; c = cyc + 1; pv = 0;
        pend.wt = 0; pend.p = 0; pend.wcyc = 0;
        foreach (plan[k]) begin
            nt  = (plan[k].tv < 0) ? t : plan[k].tv;
            inc = plan[k].e && !plan[k].l && (p < PMAX);
            dec = plan[k].l && !plan[k].e && (p > 0);
            if (inc) p++;
            if (dec) p--;
            if (inc || dec || (nt != t)) begin
                if (pv && c > pend.wcyc) sb.push_back(pend);
                pend.wt   = ref_wait(p, nt);
                pend.p    = p;
                pend.wcyc = c + ((p == 0 || p == PMAX || nt == 0) ? 2 : 10);
                pv = 1;
            end
            t = nt;
            c += 1 + plan[k].gap;
        end
        if (pv) sb.push_back(pend);
        mp = p; mt = t;
        foreach (plan[k]) begin
            enter = plan[k].e;
            leave = plan[k].l;
            if (plan[k].tv >= 0) tcount = 2'(plan[k].tv);
            @(posedge clk);
            @(negedge clk);
            enter = 1'b0;
            leave = 1'b0;
            repeat (plan[k].gap) @(negedge clk);
        end
        plan.delete();
        if (do_settle) settle();
    endtask

    // Monitor: every rising wvalid must match the oldest queued expectation.
    initial begin
        bit         pv;
        logic [5:0] pw;
        exp_t       e;
        pv = 1'b1;
        pw = '0;
        forever begin
            @(negedge clk);
            if (reset && wvalid && !pv) begin
                chk("result_expected", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wtime", wtime, e.wt);
                    chk("pcount", pcount, e.p);
                    chk("result_cycle", cyc, e.wcyc);
                    chk("ef", ef, (e.p == 0) ? 1 : 0);
                    chk("ff", ff, (e.p == PMAX) ? 1 : 0);
                    chk("busy_when_valid", busy, 0);
                end
            end
            if (reset && (wtime != pw)) chk("wtime_changed_while_busy", wvalid, 1);
            pv = wvalid;
            pw = wtime;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, r, g;
        repeat (3) @(negedge clk);
        chk("rst_pcount", pcount, 0);
        chk("rst_ef", ef, 1);
        chk("rst_ff", ff, 0);
        chk("rst_wtime", wtime, 0);
        chk("rst_wvalid", wvalid, 1);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // First nonzero tcount after reset triggers (p=0 -> 0)
        add(0, 0, 2, 0); run_burst(1);
        // t=2, two enters -> 5
        add(1, 0, -1, 0); add(1, 0, -1, 0); run_burst(1);
        // t=1, reach p=7 -> 21, then t=3 -> 9
        add(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(1, 0, -1, 0);
        run_burst(1);
        add(0, 0, 3, 0); run_burst(1);
        // p=4 -> 6, t=0 -> 63 quickly, then p=0 with t=2 -> 0
        for (int i = 0; i < 3; i++) add(0, 1, -1, 0);
        run_burst(1);
        add(0, 0, 0, 0); run_burst(1);
        for (int i = 0; i < 4; i++) add(0, 1, -1, 0);
        add(0, 0, 2, 0); run_burst(1);
        // t=1, p=4 -> 12; enter to p=5 then restart mid-CALC with p=6 -> 18 only
        add(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(1, 0, -1, 0);
        run_burst(1);
        add(1, 0, -1, 3); add(1, 0, -1, 0); run_burst(1);
        // Fill to capacity, then ignored enter and cancelling enter/leave
        for (int i = 0; i < 16; i++) add(1, 0, -1, 0);
        run_burst(1);
        add(1, 0, -1, 0); add(1, 1, -1, 0); run_burst(1);
        chk("pcount_hold_full", pcount, 15);
        chk("ff_hold_full", ff, 1);

        // Reset in the middle of a division
        for (int i = 0; i < 10; i++) add(0, 1, -1, 0);
        run_burst(0);
        repeat (4) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        tcount = 2'd0;
        #1;
        sb.delete();
        mp = 0; mt = 0;
        @(posedge clk); #1;
        chk("midcalc_rst_pcount", pcount, 0);
        chk("midcalc_rst_busy", busy, 0);
        chk("midcalc_rst_wvalid", wvalid, 1);
        chk("midcalc_rst_wtime", wtime, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        add(0, 0, 2, 0); run_burst(1);

        // Randomized bursts with short gaps to exercise restarts
        repeat (60) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 9));
                g = int'($urandom_range(0, 3));
                if (r < 4) add(1, 0, -1, g);
                else if (r < 7) add(0, 1, -1, g);
                else if (r == 7) add(1, 1, -1, g);
                else add(0, 0, int'($urandom_range(0, 3)), g);
            end
            run_burst(1);
        end

        chk("final_pcount", pcount, mp);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
